// File: rtl/fwft_prefetch_adapter.sv
// fwft_prefetch_adapter
//
// Turns a standard (registered-output) FIFO into a first-word-fall-through
// FIFO. Reads are issued upstream ahead of demand into a small circular
// prefetch buffer of READ_LATENCY+1 entries. That depth is just enough to
// sustain one pop per cycle across the upstream read latency.
//
// Parameters
//   DATA_WIDTH    word width in bits (1..1024)
//   READ_LATENCY  upstream read latency in cycles (1..4)
//
// Ports
//   clk         clock, rising edge
//   rstn        asynchronous active-low reset
//   std_empty   upstream FIFO empty flag
//   std_rd_en   read strobe to the upstream FIFO
//   std_dout    upstream read data, valid READ_LATENCY edges after a read
//   fwft_empty  high when no word is presented on fwft_dout
//   fwft_rd_en  consumer pop strobe (ignored while fwft_empty is high)
//   fwft_dout   head-of-queue word
//   fwft_level  buffered word count; present only when FWFT_PREFETCH_LEVEL_EN
//               is defined
//
// Optional feature macro: FWFT_PREFETCH_LEVEL_EN

module fwft_prefetch_adapter #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  std_empty,
    output logic                  std_rd_en,
    input  logic [DATA_WIDTH-1:0] std_dout,
    output logic                  fwft_empty,
    input  logic                  fwft_rd_en,
    output logic [DATA_WIDTH-1:0] fwft_dout
`ifdef FWFT_PREFETCH_LEVEL_EN
    ,
    output logic [$clog2(READ_LATENCY+2)-1:0] fwft_level
`endif
);

    localparam int BUF_DEPTH = READ_LATENCY + 1;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W+1)'(BUF_DEPTH);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $fatal(1, "fwft_prefetch_adapter: READ_LATENCY must be 1..4");
        end
        if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
            $fatal(1, "fwft_prefetch_adapter: DATA_WIDTH must be 1..1024");
        end
    endgenerate

    logic [DATA_WIDTH-1:0]   buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        buf_count_q, buf_count_d;
    logic [READ_LATENCY-1:0] valid_q, valid_d;
    // Holds off upstream reads until the first edge after reset release.
    logic                    run_q;

    logic             capture;
    logic             pop;
    logic [CNT_W-1:0] inflight_count;
    logic [CNT_W:0]   occ_after_pop;

    assign capture    = valid_q[READ_LATENCY-1];
    assign fwft_empty = (buf_count_q == '0);
    assign pop        = fwft_rd_en & ~fwft_empty;
    // Masked so the output is a clean zero whenever nothing is presented.
    assign fwft_dout  = fwft_empty ? '0 : buf_q[rd_ptr_q];

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_count = inflight_count + {{(CNT_W-1){1'b0}}, valid_q[i]};
        end
    end

    // Counting the pop of this cycle lets a freed slot be refilled at once,
    // which is what gives back-to-back throughput.
    assign occ_after_pop = {1'b0, buf_count_q} + {1'b0, inflight_count}
                         - {{CNT_W{1'b0}}, pop};
    assign std_rd_en     = run_q & ~std_empty & (occ_after_pop < DEPTH_EXT);

    always_comb begin
        valid_d    = '0;
        valid_d[0] = std_rd_en;
        for (int i = 1; i < READ_LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_count_d = buf_count_q;
        if (capture) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({capture, pop})
            2'b10:   buf_count_d = buf_count_q + 1'b1;
            2'b01:   buf_count_d = buf_count_q - 1'b1;
            default: buf_count_d = buf_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            buf_count_q <= '0;
            valid_q     <= '0;
            run_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_count_q <= buf_count_d;
            valid_q     <= valid_d;
            run_q       <= 1'b1;
        end
    end

    // Data storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q[wr_ptr_q] <= std_dout;
        end
    end

`ifdef FWFT_PREFETCH_LEVEL_EN
    assign fwft_level = buf_count_q;
`endif

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert ({1'b0, buf_count_q} + {1'b0, inflight_count} <= DEPTH_EXT);
        end
    end

endmodule
